// File: rtl/rv_pkg.sv
// Shared definitions for the RV32I fetch-side PC sequencing logic.
package rv_pkg;

   localparam int unsigned XLEN_DEF = 32;

   localparam logic [2:0] F3_BEQ = 3'b000;
   localparam logic [2:0] F3_BNE = 3'b001;
   localparam logic [2:0] F3_BLT = 3'b100;
   localparam logic [2:0] F3_BGE = 3'b101;

   typedef enum logic {
      RUN  = 1'b0,
      HOLD = 1'b1
   } pc_state_t;

endpackage

// File: rtl/branch_cond_eval.sv
// Conditional-branch resolution from funct3 and the Execute ALU flags.
module branch_cond_eval
   import rv_pkg::*;
(
   input  logic [2:0] funct3_i,
   input  logic       zero_i,
   input  logic       alur31_i,
   output logic       cond_o
);

   // alur31 is the sign of rs1-rs2, so it stands in for the signed less-than result.
   always_comb begin
      cond_o = 1'b0;
      case (funct3_i)
         F3_BEQ:  cond_o = zero_i;
         F3_BNE:  cond_o = ~zero_i;
         F3_BLT:  cond_o = alur31_i;
         F3_BGE:  cond_o = ~alur31_i;
         default: cond_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// Fetch PC register, Execute-stage redirect resolution with stall-time hold,
// pipeline flush generation and saturating branch statistics.
module pc_redirect_ctrl
   import rv_pkg::*;
#(
   parameter int unsigned     XLEN     = XLEN_DEF,
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter int unsigned     CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall_f,
   input  logic             ex_valid,
   input  logic             ex_jump,
   input  logic             ex_branch,
   input  logic [2:0]       ex_funct3,
   input  logic             ex_zero,
   input  logic             ex_alur31,
   input  logic [XLEN-1:0]  ex_target,
   output logic [XLEN-1:0]  pc_f,
   output logic [XLEN-1:0]  pc_plus4_f,
   output logic             flush_d,
   output logic             flush_e,
   output logic             redirect,
   output logic             misalign,
   output logic [CNT_W-1:0] br_cnt,
   output logic [CNT_W-1:0] taken_cnt
);

   pc_state_t        state_q, state_d;
   logic [XLEN-1:0]  pc_q, pc_d;
   logic [XLEN-1:0]  pend_q, pend_d;
   logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
   logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;
   logic             redirect_q, redirect_d;
   logic             misalign_q, misalign_d;

   logic            cond;
   logic            take;
   logic            take_run;
   logic            br_eval;
   logic [XLEN-1:0] tgt;

   branch_cond_eval u_cond (
      .funct3_i (ex_funct3),
      .zero_i   (ex_zero),
      .alur31_i (ex_alur31),
      .cond_o   (cond)
   );

   assign take     = ex_valid & (ex_jump | (ex_branch & cond));
   // A take seen while holding is a protocol violation and must leave no trace.
   assign take_run = take & (state_q == RUN);
   assign br_eval  = ex_valid & ex_branch & ~ex_jump & (state_q == RUN);
   assign tgt      = {ex_target[XLEN-1:2], 2'b00};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= RUN;
         pc_q        <= RESET_PC;
         pend_q      <= '0;
         br_cnt_q    <= '0;
         taken_cnt_q <= '0;
         redirect_q  <= 1'b0;
         misalign_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         pend_q      <= pend_d;
         br_cnt_q    <= br_cnt_d;
         taken_cnt_q <= taken_cnt_d;
         redirect_q  <= redirect_d;
         misalign_q  <= misalign_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      pend_d      = pend_q;
      br_cnt_d    = br_cnt_q;
      taken_cnt_d = taken_cnt_q;
      redirect_d  = 1'b0;
      misalign_d  = take_run & (ex_target[1:0] != 2'b00);

      if (br_eval && (br_cnt_q != '1)) begin
         br_cnt_d = br_cnt_q + CNT_W'(1);
      end
      if (take_run && (taken_cnt_q != '1)) begin
         taken_cnt_d = taken_cnt_q + CNT_W'(1);
      end

      unique case (state_q)
         RUN: begin
            if (take) begin
               if (stall_f) begin
                  pend_d  = tgt;
                  state_d = HOLD;
               end else begin
                  pc_d       = tgt;
                  redirect_d = 1'b1;
               end
            end else if (!stall_f) begin
               pc_d = pc_q + XLEN'(4);
            end
         end
         HOLD: begin
            if (!stall_f) begin
               pc_d       = pend_q;
               redirect_d = 1'b1;
               state_d    = RUN;
            end
         end
         default: state_d = RUN;
      endcase
   end

   // Only the taking cycle kills ID/EX; IF/ID is killed for every held cycle.
   always_comb begin
      flush_d = 1'b0;
      flush_e = 1'b0;
      unique case (state_q)
         RUN: begin
            flush_d = take;
            flush_e = take;
         end
         HOLD: flush_d = 1'b1;
         default: ;
      endcase
   end

   assign pc_f       = pc_q;
   assign pc_plus4_f = pc_q + XLEN'(4);
   assign redirect   = redirect_q;
   assign misalign   = misalign_q;
   assign br_cnt     = br_cnt_q;
   assign taken_cnt  = taken_cnt_q;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Randomized scoreboard bench for pc_redirect_ctrl against a behavioural PC model.
module tb_pc_redirect_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall_f;
   logic        ex_valid;
   logic        ex_jump;
   logic        ex_branch;
   logic [2:0]  ex_funct3;
   logic        ex_zero;
   logic        ex_alur31;
   logic [31:0] ex_target;
   logic [31:0] pc_f;
   logic [31:0] pc_plus4_f;
   logic        flush_d;
   logic        flush_e;
   logic        redirect;
   logic        misalign;
   logic [15:0] br_cnt;
   logic [15:0] taken_cnt;

   always #5 clk = ~clk;

   pc_redirect_ctrl #(
      .XLEN     (32),
      .RESET_PC (32'h0000_0000),
      .CNT_W    (16)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .stall_f    (stall_f),
      .ex_valid   (ex_valid),
      .ex_jump    (ex_jump),
      .ex_branch  (ex_branch),
      .ex_funct3  (ex_funct3),
      .ex_zero    (ex_zero),
      .ex_alur31  (ex_alur31),
      .ex_target  (ex_target),
      .pc_f       (pc_f),
      .pc_plus4_f (pc_plus4_f),
      .flush_d    (flush_d),
      .flush_e    (flush_e),
      .redirect   (redirect),
      .misalign   (misalign),
      .br_cnt     (br_cnt),
      .taken_cnt  (taken_cnt)
   );

   typedef struct {
      logic [31:0] pc;
      logic [31:0] pc4;
      logic        fd;
      logic        fe;
      logic        red;
      logic        mis;
      logic [15:0] br;
      logic [15:0] tk;
   } exp_t;

   exp_t q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   // Reference model: architectural view of the sequencer.
   logic        m_live = 1'b0;
   logic        m_hold;
   logic [31:0] m_pc, m_pend;
   logic [15:0] m_br, m_tk;
   logic        m_red, m_mis;

   function automatic logic cond_of(input logic [2:0] f3, input logic z, input logic a);
      case (f3)
         3'b000:  return z;
         3'b001:  return !z;
         3'b100:  return a;
         3'b101:  return !a;
         default: return 1'b0;
      endcase
   endfunction

   task automatic cyc(input logic r, input logic s, input logic v, input logic j,
                      input logic b, input logic [2:0] f3, input logic z, input logic a,
                      input logic [31:0] t);
      exp_t e;
      logic tk_;
      @(negedge clk);
      rst = r; stall_f = s; ex_valid = v; ex_jump = j; ex_branch = b;
      ex_funct3 = f3; ex_zero = z; ex_alur31 = a; ex_target = t;
      tk_ = v && (j || (b && cond_of(f3, z, a)));
      if (m_live) begin
         e.pc  = m_pc;
         e.pc4 = m_pc + 32'd4;
         e.fd  = m_hold || tk_;
         e.fe  = !m_hold && tk_;
         e.red = m_red;
         e.mis = m_mis;
         e.br  = m_br;
         e.tk  = m_tk;
         q.push_back(e);
      end
      if (r) begin
         m_live = 1'b1; m_hold = 1'b0; m_pc = 32'h0; m_pend = 32'h0;
         m_br = 16'h0; m_tk = 16'h0; m_red = 1'b0; m_mis = 1'b0;
      end else if (m_live) begin
         if (!m_hold) begin
            if (v && b && !j && m_br != 16'hFFFF) m_br = m_br + 16'd1;
            if (tk_ && m_tk != 16'hFFFF) m_tk = m_tk + 16'd1;
            m_mis = tk_ && (t[1:0] != 2'b00);
            m_red = 1'b0;
            if (tk_ && s) begin
               m_pend = {t[31:2], 2'b00};
               m_hold = 1'b1;
            end else if (tk_) begin
               m_pc  = {t[31:2], 2'b00};
               m_red = 1'b1;
            end else if (!s) begin
               m_pc = m_pc + 32'd4;
            end
         end else begin
            m_mis = 1'b0;
            m_red = 1'b0;
            if (!s) begin
               m_pc   = m_pend;
               m_hold = 1'b0;
               m_red  = 1'b1;
            end
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 3'b000, 0, 0, 32'h0);
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Monitor: every cycle after reset presents a full output set.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("pc_f", pc_f, e.pc);
            chk("pc_plus4_f", pc_plus4_f, e.pc4);
            chk("flush_d", {31'b0, flush_d}, {31'b0, e.fd});
            chk("flush_e", {31'b0, flush_e}, {31'b0, e.fe});
            chk("redirect", {31'b0, redirect}, {31'b0, e.red});
            chk("misalign", {31'b0, misalign}, {31'b0, e.mis});
            chk("br_cnt", {16'b0, br_cnt}, {16'b0, e.br});
            chk("taken_cnt", {16'b0, taken_cnt}, {16'b0, e.tk});
         end
      end
   end

   initial begin
      logic [2:0] f3s [6];
      f3s[0] = 3'b000; f3s[1] = 3'b001; f3s[2] = 3'b100;
      f3s[3] = 3'b101; f3s[4] = 3'b010; f3s[5] = 3'b111;

      cyc(1, 0, 0, 0, 0, 3'b000, 0, 0, 32'h0);
      idle(4);
      // Taken BEQ at pc 0x10, then not-taken BLT and undefined funct3.
      cyc(0, 0, 1, 0, 1, 3'b000, 1, 0, 32'h80);
      cyc(0, 0, 1, 0, 1, 3'b100, 0, 0, 32'h40);
      cyc(0, 0, 1, 0, 1, 3'b010, 1, 0, 32'h40);
      idle(1);
      // Stalled JAL, ignored take during HOLD, release.
      cyc(0, 1, 1, 1, 0, 3'b111, 0, 0, 32'h200);
      cyc(0, 1, 1, 1, 0, 3'b000, 0, 0, 32'h300);
      cyc(0, 1, 1, 0, 1, 3'b000, 1, 0, 32'h340);
      cyc(0, 0, 0, 0, 0, 3'b000, 0, 0, 32'h0);
      idle(2);
      // Misaligned JALR, then reset while holding.
      cyc(0, 0, 1, 1, 0, 3'b000, 0, 0, 32'h103);
      idle(2);
      cyc(0, 1, 1, 1, 0, 3'b000, 0, 0, 32'h500);
      cyc(1, 1, 0, 0, 0, 3'b000, 0, 0, 32'h0);
      idle(3);
      // Saturate taken_cnt.
      for (int i = 0; i < 65537; i++) cyc(0, 0, 1, 1, 0, 3'b000, 0, 0, 32'h40);
      idle(1);
      // PC wrap.
      cyc(0, 0, 1, 1, 0, 3'b000, 0, 0, 32'hFFFF_FFFC);
      idle(3);
      cyc(1, 0, 0, 0, 0, 3'b000, 0, 0, 32'h0);
      for (int i = 0; i < 3000; i++) begin
         logic [31:0] t;
         t = $urandom;
         if ($urandom_range(0, 1) == 0) t[1:0] = 2'b00;
         cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 2) == 0),
             ($urandom_range(0, 3) != 0), ($urandom_range(0, 4) == 0),
             ($urandom_range(0, 1) == 1), f3s[$urandom_range(0, 5)],
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), t);
      end
      idle(1);
      @(negedge clk);
      #3;
      n_tests++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d left expected 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/pc_redirect_ctrl.md
Name: pc_redirect_ctrl

Overview:
Fetch-side PC sequencer for the 5-stage RV32I core. It owns the fetch PC register and resolves Execute-stage branches and jumps (BEQ/BNE/BLT/BGE, JAL/JALR). It issues decode and execute flushes, and holds a resolved redirect pending while fetch is stalled. It also keeps saturating branch statistics for performance debug.

Parameters:
XLEN, 32, datapath/PC width
RESET_PC, 32'h0000_0000, fetch PC after reset
CNT_W, 16, width of statistics counters

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
stall_f  in  1  fetch stall from hazard unit / imem not ready; PC must hold
ex_valid  in  1  Execute stage holds a real instruction (not a bubble)
ex_jump  in  1  Execute instruction is JAL/JALR
ex_branch  in  1  Execute instruction is a conditional branch
ex_funct3  in  3  branch funct3 from Execute
ex_zero  in  1  ALU zero flag
ex_alur31  in  1  ALU result bit 31 (sign of rs1-rs2)
ex_target  in  XLEN  branch/jump target computed in Execute
pc_f  out  XLEN  current fetch PC (registered)
pc_plus4_f  out  XLEN  pc_f + 4 (combinational)
flush_d  out  1  kill IF/ID register contents
flush_e  out  1  kill ID/EX register contents
redirect  out  1  one-cycle pulse on the edge pc_f loads a redirect target
misalign  out  1  one-cycle pulse: taken target had target[1:0] != 0
br_cnt  out  CNT_W  conditional branches evaluated (saturating)
taken_cnt  out  CNT_W  taken redirects, jumps included (saturating)

Behaviour:
- Interface: single clock clk; reset rst is synchronous and active-high.
- Reset (rst=1 at edge): pc_f=RESET_PC, state=RUN, pend_pc=0, br_cnt=0, taken_cnt=0, redirect=0, misalign=0. rst overrides every simultaneous event.
- Condition: cond = (f3==000)&zero | (f3==001)&~zero | (f3==100)&alur31 | (f3==101)&~alur31. Other funct3 values give 0.
- Take: take = ex_valid & (ex_jump | ex_branch & cond). ex_jump takes priority; ex_funct3 is ignored when ex_jump=1.
- Target: tgt = {ex_target[XLEN-1:2],2'b00}. misalign pulses the cycle after a take with ex_target[1:0]!=0.
- States: RUN, HOLD.
- RUN, take & ~stall_f: next pc_f=tgt, redirect=1 next cycle. flush_d=flush_e=1 combinationally this cycle.
- RUN, take & stall_f: pend_pc<=tgt, go to HOLD. flush_d=flush_e=1 this cycle. pc_f holds.
- RUN, ~take & ~stall_f: pc_f<=pc_f+4, wrapping modulo 2^XLEN.
- RUN, ~take & stall_f: pc_f holds. No flush.
- HOLD: flush_d=1 every cycle; flush_e=0. When stall_f=0: pc_f<=pend_pc, redirect pulses, go to RUN. When stall_f=1: stay in HOLD.
- take while in HOLD is a pipeline protocol violation and is ignored: pend_pc is not overwritten and counters do not count it.
- Latency: a taken branch at edge N gives pc_f=target after edge N+1 when unstalled, and 2 wrong-path instructions are flushed.
- Counters: br_cnt increments on ex_valid & ex_branch & ~ex_jump in RUN. taken_cnt increments on take in RUN. Both saturate at all-ones. They are not affected by stall_f.
- Reset in HOLD discards pend_pc and returns to RUN with pc_f=RESET_PC.

Decomposition:
- Shared package rv_pkg: F3_BEQ=000, F3_BNE=001, F3_BLT=100, F3_BGE=101; pc_state_t {RUN,HOLD}; XLEN default.
- One sub-module, branch_cond_eval: combinational funct3/zero/alur31 -> cond. The FSM, PC register and counters stay in pc_redirect_ctrl.

Test Plan:
- Reset then 3 unstalled cycles, no ex_valid -> pc_f 0x0,0x4,0x8,0xC; flush_d=flush_e=0; counters 0.
- pc_f=0x10, ex_branch=1, f3=000, zero=1, target 0x80 -> flush_d=flush_e=1 that cycle; next pc_f=0x80, redirect=1; br_cnt=1, taken_cnt=1.
- BLT with alur31=0, target 0x40 -> no flush, pc_f advances +4; br_cnt +1, taken_cnt unchanged. f3=010 with zero=1 -> not taken.
- JAL target 0x200 with stall_f=1 for 3 cycles -> state HOLD, pc_f held, flush_d=1 for 3 cycles; on stall release pc_f=0x200, redirect pulse. A take injected during HOLD is ignored.
- JALR target 0x103 -> pc_f=0x100, misalign pulses once; rst asserted mid-HOLD -> pc_f=RESET_PC, state RUN.
- Preload counters near 0xFFFF via 65535 taken jumps, then 2 more -> taken_cnt stays 0xFFFF; pc_f=0xFFFF_FFFC unstalled -> wraps to 0x0.
